i2c_cmd_seq: RTL and testbench

I2C_CMD_SEQ -- requirements
Module: i2c_cmd_seq

---
 rtl/i2c_cmd_seq.sv | 140 ++++++++++++++
 tb/tb_i2c_cmd_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_seq.sv
// Command sequencer that turns one I2C command into a fixed series of register
// writes, a timed wait, an optional read-back and a one-cycle response pulse.
// Optional transaction counter enabled by defining I2C_CMD_SEQ_TXN_COUNT_EN.
module i2c_cmd_seq #(
  parameter int WAIT_CYCLES = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_slave_addr,
  input  logic        cmd_rw,
  input  logic [7:0]  cmd_reg_addr,
  input  logic [31:0] cmd_wdata,
  output logic [2:0]  address,
  output logic [31:0] write_data,
  output logic        we,
  output logic        re,
  input  logic [31:0] read_data,
  output logic        rsp_valid,
  output logic        rsp_rw,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [15:0] txn_count
);

  typedef enum logic [3:0] {
    IDLE, W_SADDR, W_RW, W_RADDR, W_DATA, START, CLR, WAIT, RD_REQ, RD_CAP, RESP
  } state_t;

  localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        accept;
  logic [6:0]  slave_q;
  logic        rw_q;
  logic [7:0]  reg_q;
  logic [31:0] wdata_q;
  logic [2:0]  addr_d;
  logic [31:0] wdata_d;
  logic        we_d, re_d;

  // cmd_ready is only ever high in IDLE, so this is the handshake edge
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    addr_d    = 3'd0;
    wdata_d   = 32'd0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = W_SADDR;
      W_SADDR: state_nxt = W_RW;
      W_RW:    state_nxt = W_RADDR;
      W_RADDR: state_nxt = W_DATA;
      W_DATA:  state_nxt = START;
      START:   state_nxt = CLR;
      CLR:     state_nxt = WAIT;
      WAIT:    if (wait_cnt == 16'd0) state_nxt = rw_q ? RD_REQ : RESP;
      RD_REQ:  state_nxt = RD_CAP;
      RD_CAP:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Outputs are decoded from the next state so the registers line up with it;
    // W_SADDR is only entered on the accept edge, before the payload is captured.
    case (state_nxt)
      W_SADDR: begin addr_d = 3'd1; wdata_d = {25'd0, cmd_slave_addr}; we_d = 1'b1; end
      W_RW:    begin addr_d = 3'd2; wdata_d = {31'd0, rw_q};           we_d = 1'b1; end
      W_RADDR: begin addr_d = 3'd3; wdata_d = {24'd0, reg_q};          we_d = 1'b1; end
      W_DATA:  begin addr_d = 3'd4; wdata_d = wdata_q;                 we_d = 1'b1; end
      START:   begin addr_d = 3'd0; wdata_d = 32'd1;                   we_d = 1'b1; end
      CLR:     begin addr_d = 3'd0; wdata_d = 32'd0;                   we_d = 1'b1; end
      RD_REQ, RD_CAP: begin addr_d = 3'd5; re_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 16'd0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      address    <= 3'd0;
      write_data <= 32'd0;
      we         <= 1'b0;
      re         <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rw     <= 1'b0;
      rsp_rdata  <= 32'd0;
    end else begin
      state      <= state_nxt;
      cmd_ready  <= (state_nxt == IDLE);
      busy       <= (state_nxt != IDLE);
      address    <= addr_d;
      write_data <= wdata_d;
      we         <= we_d;
      re         <= re_d;
      rsp_valid  <= (state_nxt == RESP);
      rsp_rw     <= (state_nxt == RESP) && rw_q;
      if (state == CLR)
        wait_cnt <= WAIT_LOAD;
      else if (state == WAIT && wait_cnt != 16'd0)
        wait_cnt <= wait_cnt - 16'd1;
      // Cleared per command so a write always responds with zero data
      if (accept)
        rsp_rdata <= 32'd0;
      else if (state == RD_CAP)
        rsp_rdata <= read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      slave_q <= cmd_slave_addr;
      rw_q    <= cmd_rw;
      reg_q   <= cmd_reg_addr;
      wdata_q <= cmd_wdata;
    end
  end

`ifdef I2C_CMD_SEQ_TXN_COUNT_EN
  logic [15:0] txn_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      txn_count_q <= 16'd0;
    else if (state == RESP)
      txn_count_q <= txn_count_q + 16'd1;
  end

  assign txn_count = txn_count_q;
`else
  assign txn_count = 16'd0;
`endif

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Self-checking bench for i2c_cmd_seq: directed and random commands compared
// cycle by cycle against a table-driven model of the command timeline.
module tb_i2c_cmd_seq;

  localparam int W = 150;

  typedef struct packed {
    logic [6:0]  slave;
    logic        rw;
    logic [7:0]  regad;
    logic [31:0] wdata;
    logic [31:0] rdv;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_slave_addr = '0;
  logic        cmd_rw = 1'b0;
  logic [7:0]  cmd_reg_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [2:0]  address;
  logic [31:0] write_data;
  logic        we, re;
  logic [31:0] read_data;
  logic        rsp_valid, rsp_rw;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [15:0] txn_count;

  logic [31:0] rd_model = 32'h0;
  logic [15:0] exp_txn = 16'h0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Downstream i2c block model: returns the programmed value only while read is strobed
  assign read_data = re ? rd_model : 32'hDEAD_BEEF;

  i2c_cmd_seq #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_slave_addr(cmd_slave_addr), .cmd_rw(cmd_rw), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .address(address), .write_data(write_data), .we(we), .re(re),
    .read_data(read_data), .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_rdata(rsp_rdata),
    .busy(busy), .txn_count(txn_count)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic drive_payload(input cmd_t c);
    cmd_slave_addr = c.slave;
    cmd_rw         = c.rw;
    cmd_reg_addr   = c.regad;
    cmd_wdata      = c.wdata;
  endtask

  task automatic scramble_payload();
    cmd_slave_addr = 7'($urandom);
    cmd_rw         = 1'($urandom);
    cmd_reg_addr   = 8'($urandom);
    cmd_wdata      = $urandom;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.slave = 7'($urandom);
    c.rw    = 1'($urandom);
    c.regad = 8'($urandom);
    c.wdata = $urandom;
    c.rdv   = $urandom;
    return c;
  endfunction

  // Present a command and return right after the accepting rising edge
  task automatic issue(input cmd_t c);
    int n;
    @(negedge clk);
    drive_payload(c);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: cmd_ready=%b required 1 within 1000 cycles", cmd_ready);
    end
    rd_model = c.rdv;
    @(posedge clk);
  endtask

  // Walk the command timeline from cycle 1 to the first IDLE cycle after RESP
  task automatic check_txn(input cmd_t c, input logic hold, input cmd_t nxt);
    int r;
    logic [2:0]  e_addr;
    logic [31:0] e_data;
    logic        e_we, e_re, e_vld, e_rdy;
    logic [40:0] got, exp;
    r = 7 + W + (c.rw ? 2 : 0);
    for (int k = 1; k <= r + 1; k++) begin
      @(negedge clk);
      e_addr = 3'd0; e_data = 32'd0; e_we = 1'b0; e_re = 1'b0;
      e_vld = (k == r);
      e_rdy = (k == r + 1);
      if (k <= 6) begin
        e_we = 1'b1;
        case (k)
          1: begin e_addr = 3'd1; e_data = {25'd0, c.slave}; end
          2: begin e_addr = 3'd2; e_data = {31'd0, c.rw}; end
          3: begin e_addr = 3'd3; e_data = {24'd0, c.regad}; end
          4: begin e_addr = 3'd4; e_data = c.wdata; end
          5: begin e_addr = 3'd0; e_data = 32'd1; end
          default: begin e_addr = 3'd0; e_data = 32'd0; end
        endcase
      end else if (c.rw && k >= 7 + W && k < r) begin
        e_addr = 3'd5;
        e_re   = 1'b1;
      end
      got = {address, write_data, we, re, rsp_valid, cmd_ready, busy};
      exp = {e_addr, e_data, e_we, e_re, e_vld, e_rdy, ~e_rdy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL timeline cycle %0d: {addr,data,we,re,vld,rdy,busy}=%h required %h", k, got, exp);
      end
      if (k == r) begin
        checks++;
        if ({rsp_rw, rsp_rdata} !== {c.rw, (c.rw ? c.rdv : 32'd0)}) begin
          errors++;
          $display("FAIL response: rsp_rw/rdata=%b/%h required %b/%h", rsp_rw, rsp_rdata,
                   c.rw, (c.rw ? c.rdv : 32'd0));
        end
      end
      if (k == r + 1) begin
`ifdef I2C_CMD_SEQ_TXN_COUNT_EN
        exp_txn = exp_txn + 16'd1;
`endif
        checks++;
        if (txn_count !== exp_txn) begin
          errors++;
          $display("FAIL txn_count: got %h required %h", txn_count, exp_txn);
        end
      end
      if (k == 1) begin
        if (hold) begin
          drive_payload(nxt);
          cmd_valid = 1'b1;
        end else begin
          cmd_valid = 1'b0;
          scramble_payload();
        end
      end
    end
  endtask

  task automatic run_one(input cmd_t c);
    issue(c);
    check_txn(c, 1'b0, c);
  endtask

  task automatic check_reset_values(input string tag);
    logic [88:0] got, exp;
    got = {cmd_ready, busy, address, write_data, we, re, rsp_valid, rsp_rw, rsp_rdata, txn_count};
    exp = {1'b1, 88'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs=%h required %h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scramble_payload();
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_state");
    cmd_valid = 1'b0;
    rst = 1'b0;
    exp_txn = 16'h0;
    @(negedge clk);
    check_reset_values("after_reset_idle");
  endtask

  task automatic test_write();
    cmd_t c;
    c = '{slave: 7'h63, rw: 1'b0, regad: 8'h0B, wdata: 32'h58AE_1234, rdv: 32'h0};
    run_one(c);
  endtask

  task automatic test_read();
    cmd_t c;
    c = '{slave: 7'h63, rw: 1'b1, regad: 8'h0F, wdata: 32'h0, rdv: 32'hA5A5_1234};
    run_one(c);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_one(rand_cmd());
  endtask

  task automatic test_back_to_back();
    cmd_t a, b;
    a = rand_cmd();
    b = rand_cmd();
    a.rw = 1'b1;
    issue(a);
    check_txn(a, 1'b1, b);
    @(posedge clk);
    rd_model = b.rdv;
    check_txn(b, 1'b0, b);
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    c = rand_cmd();
    c.rw = 1'b0;
    issue(c);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        scramble_payload();
      end
    end
    rst = 1'b1;
    #1;
    check_reset_values("reset_mid_wait");
    exp_txn = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
        errors++;
        $display("FAIL post_reset_idle %0d: vld/rdy/busy=%b required 010", k, {rsp_valid, cmd_ready, busy});
      end
    end
    run_one(rand_cmd());
  endtask

  task automatic test_txn_count();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_txn = 16'h0;
    for (int i = 0; i < 3; i++) run_one(rand_cmd());
    checks++;
`ifdef I2C_CMD_SEQ_TXN_COUNT_EN
    if (txn_count !== 16'd3) begin
      errors++;
      $display("FAIL txn_count_three: got %h required 0003", txn_count);
    end
    @(negedge clk);
    force dut.txn_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count_q;
    exp_txn = 16'hFFFF;
    run_one(rand_cmd());
    checks++;
    if (txn_count !== 16'h0000) begin
      errors++;
      $display("FAIL txn_count_wrap: got %h required 0000", txn_count);
    end
`else
    if (txn_count !== 16'h0000) begin
      errors++;
      $display("FAIL txn_count_disabled: got %h required 0000", txn_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_txn_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
